// File: rtl/ram_arbiter_2p_pkg.sv
// Shared types for the two-port RAM arbiter: FSM encoding, requester ids
// and the round-robin tie-break helper.
package ram_arbiter_2p_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_e;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  // On a tie the side that was not served last wins.
  function automatic side_e tie_winner(input side_e last);
    return (last == SIDE_A) ? SIDE_B : SIDE_A;
  endfunction

endpackage

// File: rtl/ram_arb_port_rsp.sv
// Per-requester read response stage: captures RAM read data one cycle
// after an accepted read and raises a single-cycle valid pulse.
module ram_arb_port_rsp
  import ram_arbiter_2p_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rd_fire_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o
);

  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Next response: load on an accepted read, otherwise hold the last data.
  always_comb begin
    rvalid_d = rd_fire_i;
    if (rd_fire_i) begin
      rdata_d = mem_rdata_i;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= {DW{1'b0}};
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter sharing one single-access RAM between requesters A
// and B, with bounded locked bursts and registered read responses.
module ram_arbiter_2p
  import ram_arbiter_2p_pkg::*;
#(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int             LCW       = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

  state_e         state_q, state_d;
  side_e          last_q, last_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           gnt_a_s, gnt_b_s;
  logic           acc_a_s, acc_b_s;

  // Grant: owner keeps the RAM while locked, otherwise round-robin on ties.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (a_valid && b_valid) begin
          if (tie_winner(last_q) == SIDE_A) begin
            gnt_a_s = 1'b1;
          end else begin
            gnt_b_s = 1'b1;
          end
        end else if (a_valid) begin
          gnt_a_s = 1'b1;
        end else if (b_valid) begin
          gnt_b_s = 1'b1;
        end else begin
          gnt_a_s = 1'b0;
        end
      end
      ST_OWN_A: gnt_a_s = a_valid;
      ST_OWN_B: gnt_b_s = b_valid;
      default: begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
      end
    endcase
  end

  // No beat may transfer while reset is held.
  assign acc_a_s = gnt_a_s & a_valid & ~rst;
  assign acc_b_s = gnt_b_s & b_valid & ~rst;
  assign a_ready = acc_a_s;
  assign b_ready = acc_b_s;

  // Lock tracking: extend a burst until the count runs out or the owner goes idle.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    if (acc_a_s) begin
      if (a_lock && (lock_cnt_q < LOCK_LAST)) begin
        state_d    = ST_OWN_A;
        lock_cnt_d = lock_cnt_q + LCW'(1'b1);
      end else begin
        state_d    = ST_IDLE;
        lock_cnt_d = {LCW{1'b0}};
        last_d     = SIDE_A;
      end
    end else if (acc_b_s) begin
      if (b_lock && (lock_cnt_q < LOCK_LAST)) begin
        state_d    = ST_OWN_B;
        lock_cnt_d = lock_cnt_q + LCW'(1'b1);
      end else begin
        state_d    = ST_IDLE;
        lock_cnt_d = {LCW{1'b0}};
        last_d     = SIDE_B;
      end
    end else if ((state_q == ST_OWN_A) && !a_valid) begin
      state_d    = ST_IDLE;
      lock_cnt_d = {LCW{1'b0}};
      last_d     = SIDE_A;
    end else if ((state_q == ST_OWN_B) && !b_valid) begin
      state_d    = ST_IDLE;
      lock_cnt_d = {LCW{1'b0}};
      last_d     = SIDE_B;
    end else if (!(state_q inside {ST_IDLE, ST_OWN_A, ST_OWN_B})) begin
      state_d    = ST_IDLE;
      lock_cnt_d = {LCW{1'b0}};
    end else begin
      state_d = state_q;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= SIDE_B;
      lock_cnt_q <= {LCW{1'b0}};
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // RAM port follows the granted side; A's fields are parked when nobody is granted.
  assign mem_addr  = gnt_b_s ? b_addr : a_addr;
  assign mem_wdata = gnt_b_s ? b_wdata : a_wdata;
  assign mem_we    = (acc_a_s & a_we) | (acc_b_s & b_we);

  ram_arb_port_rsp #(.DW(DW)) u_rsp_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_fire_i   (acc_a_s & ~a_we),
    .mem_rdata_i (mem_rdata),
    .rvalid_o    (a_rvalid),
    .rdata_o     (a_rdata)
  );

  ram_arb_port_rsp #(.DW(DW)) u_rsp_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_fire_i   (acc_b_s & ~b_we),
    .mem_rdata_i (mem_rdata),
    .rvalid_o    (b_rvalid),
    .rdata_o     (b_rdata)
  );

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Self-checking bench for ram_arbiter_2p: vector table of requests with
// expected grants, a read-response scoreboard and a mid-burst reset sequence.
module tb_ram_arbiter_2p;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_we, a_lock, a_ready, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_we, b_lock, b_ready, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;

  ram_arbiter_2p #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Stand-in for RAM_async: posedge write, combinational read.
  logic [DW-1:0] ram [0:15];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  typedef struct {
    logic          av, awe, alk;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv, bwe, blk;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          ear, ebr;
  } vec_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  vec_t          vecs[$];
  rsp_t          qa[$], qb[$];
  logic [DW-1:0] exp_mem [0:15];
  logic [DW-1:0] exp_a_rdata, exp_b_rdata;
  int            cyc, n_checks, n_errors;

  function automatic vec_t mk(input logic av, awe, alk, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic bv, bwe, blk, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                              input logic ear, ebr);
    vec_t v;
    v.av = av; v.awe = awe; v.alk = alk; v.aa = aa; v.ad = ad;
    v.bv = bv; v.bwe = bwe; v.blk = blk; v.ba = ba; v.bd = bd;
    v.ear = ear; v.ebr = ebr;
    return v;
  endfunction

  task automatic chk8(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare read responses due in the current cycle against the scoreboard.
  task automatic check_rsp();
    logic ea, eb;
    ea = 1'b0;
    eb = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      ea = 1'b1;
      exp_a_rdata = qa[0].data;
      void'(qa.pop_front());
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      eb = 1'b1;
      exp_b_rdata = qb[0].data;
      void'(qb.pop_front());
    end
    chk1("a_rvalid", a_rvalid, ea);
    chk8("a_rdata", a_rdata, exp_a_rdata);
    chk1("b_rvalid", b_rvalid, eb);
    chk8("b_rdata", b_rdata, exp_b_rdata);
  endtask

  task automatic drive(input vec_t v);
    a_valid = v.av; a_we = v.awe; a_lock = v.alk; a_addr = v.aa; a_wdata = v.ad;
    b_valid = v.bv; b_we = v.bwe; b_lock = v.blk; b_addr = v.ba; b_wdata = v.bd;
  endtask

  // One cycle: drive, check grant and RAM port mid-cycle, update the model, advance.
  task automatic apply(input vec_t v);
    logic          e_we;
    logic [AW-1:0] e_addr;
    drive(v);
    @(negedge clk);
    check_rsp();
    chk1("a_ready", a_ready, v.ear);
    chk1("b_ready", b_ready, v.ebr);
    e_we   = (v.ear & v.awe) | (v.ebr & v.bwe);
    e_addr = v.ebr ? v.ba : v.aa;
    chk1("mem_we", mem_we, e_we);
    chk8("mem_addr", {4'h0, mem_addr}, {4'h0, e_addr});
    if (v.ear) begin
      if (v.awe) exp_mem[v.aa] = v.ad;
      else       qa.push_back('{cyc + 1, exp_mem[v.aa]});
    end
    if (v.ebr) begin
      if (v.bwe) exp_mem[v.ba] = v.bd;
      else       qb.push_back('{cyc + 1, exp_mem[v.ba]});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vec_t idle_v;
    n_checks = 0; n_errors = 0; cyc = 0;
    exp_a_rdata = 8'h00; exp_b_rdata = 8'h00;
    idle_v = mk(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    drive(idle_v);
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with both sides requesting writes.
    a_valid = 1'b1; a_we = 1'b1; b_valid = 1'b1; b_we = 1'b1;
    #1;
    chk1("rst_a_ready", a_ready, 1'b0);
    chk1("rst_b_ready", b_ready, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_a_rvalid", a_rvalid, 1'b0);
    chk1("rst_b_rvalid", b_rvalid, 1'b0);
    chk8("rst_a_rdata", a_rdata, 8'h00);
    chk8("rst_b_rdata", b_rdata, 8'h00);
    drive(idle_v);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    //        av   awe  alk  aa     ad     bv   bwe  blk  ba     bd     ear  ebr
    // Write then read back on A.
    vecs.push_back(mk(1'b1,1'b1,1'b0,4'd5,8'h3C, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,4'd5,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0));
    vecs.push_back(idle_v);
    // Seed two words, leaving B as last served.
    vecs.push_back(mk(1'b1,1'b1,1'b0,4'd1,8'h5A, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,1'b0,4'd3,8'hA7, 1'b0,1'b1));
    // Alternating ties: A,B,A,B.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1'b1,1'b0,1'b0,4'd1,8'h00, 1'b1,1'b0,1'b0,4'd3,8'h00, i % 2 == 0, i % 2 == 1));
    // Locked burst: A four times, then forced release to B.
    vecs.push_back(mk(1'b1,1'b0,1'b1,4'd5,8'h00, 1'b1,1'b0,1'b0,4'd1,8'h00, 1'b1,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,4'd1,8'h00, 1'b1,1'b0,1'b0,4'd1,8'h00, 1'b1,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,4'd3,8'h00, 1'b1,1'b0,1'b0,4'd1,8'h00, 1'b1,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,4'd5,8'h00, 1'b1,1'b0,1'b0,4'd1,8'h00, 1'b1,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,4'd1,8'h00, 1'b1,1'b0,1'b0,4'd1,8'h00, 1'b0,1'b1));
    // Owner going idle drops the lock: B waits one cycle, then is served.
    vecs.push_back(mk(1'b1,1'b0,1'b1,4'd1,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,1'b0,4'd9,8'h22, 1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,1'b0,4'd9,8'h22, 1'b0,1'b1));
    // Write-then-read ordering: B writes @2 while A's read @2 is held off.
    vecs.push_back(mk(1'b1,1'b1,1'b0,4'd9,8'h77, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,4'd2,8'h00, 1'b1,1'b1,1'b0,4'd2,8'h11, 1'b0,1'b1));
    vecs.push_back(mk(1'b1,1'b0,1'b0,4'd2,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0));
    vecs.push_back(idle_v);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset while A holds the lock and a read response is in flight.
    drive(mk(1'b1,1'b0,1'b1,4'd5,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0));
    @(negedge clk);
    check_rsp();
    chk1("lock_rd_a_ready", a_ready, 1'b1);
    rst = 1'b1;
    #1;
    qa.delete(); qb.delete();
    exp_a_rdata = 8'h00; exp_b_rdata = 8'h00;
    chk1("midrst_a_ready", a_ready, 1'b0);
    chk8("midrst_a_rdata", a_rdata, 8'h00);
    a_we = 1'b1;
    #1;
    chk1("midrst_mem_we", mem_we, 1'b0);
    a_we = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk1("midrst_a_rvalid", a_rvalid, 1'b0);
    chk8("midrst_a_rdata2", a_rdata, 8'h00);
    drive(idle_v);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    // Tie after reset goes to A; pre-reset RAM data survives.
    apply(mk(1'b1,1'b0,1'b0,4'd5,8'h00, 1'b1,1'b0,1'b0,4'd2,8'h00, 1'b1,1'b0));
    apply(mk(1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,4'd2,8'h00, 1'b0,1'b1));
    apply(idle_v);
    apply(idle_v);

    n_checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d/%0d responses outstanding, expected 0/0", qa.size(), qb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
